// File: rtl/note_scroll_controller_pkg.sv
// Shared definitions for the note-lane sequencer and the renderer.
//   - Arrow codes as stored in the chart ROM and in each arrow_array slot.
//   - Judgement codes shown on the player indicators.
//   - Sequencer FSM state encoding, exported on the debug port.
//   - grade_press(): scores one press against the two bottom slots.
package note_scroll_controller_pkg;

   localparam logic [2:0] ARW_NONE  = 3'b000;
   localparam logic [2:0] ARW_UP    = 3'b001;
   localparam logic [2:0] ARW_LEFT  = 3'b010;
   localparam logic [2:0] ARW_DOWN  = 3'b011;
   localparam logic [2:0] ARW_RIGHT = 3'b100;
   localparam logic [2:0] ARW_SHAKE = 3'b110;
   localparam logic [2:0] ARW_END   = 3'b111;

   localparam logic [1:0] IND_DEFAULT   = 2'b00;
   localparam logic [1:0] IND_BAD       = 2'b01;
   localparam logic [1:0] IND_GOOD      = 2'b10;
   localparam logic [1:0] IND_EXCELLENT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_RUN   = 3'd3,
      ST_SHIFT = 3'd4,
      ST_DRAIN = 3'd5,
      ST_DONE  = 3'd6
   } scroll_state_e;

   // Exact hit on the hit-zone slot beats a near hit on the slot above it;
   // an empty slot never matches.
   function automatic logic [1:0] grade_press(input logic [2:0] code,
                                              input logic [2:0] slot_hit,
                                              input logic [2:0] slot_pre);
      if (code == slot_hit && slot_hit != ARW_NONE) begin
         return IND_EXCELLENT;
      end else if (code == slot_pre && slot_pre != ARW_NONE) begin
         return IND_GOOD;
      end else begin
         return IND_BAD;
      end
   endfunction

endpackage

// File: rtl/note_scroll_controller_hit_judge.sv
// Per-player press judge and indicator hold timer.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   btn_i              player pad code (000 = none)
//   slot_hit_i         arrow in the hit zone (slot N-1)
//   slot_pre_i         arrow one slot above the hit zone (slot N-2)
//   shift_i            high for the single cycle the array scrolls
//   vsync_pulse_i      start-of-vblank pulse, paces the hold timer
//   busy_i             song in progress; judging disabled otherwise
//   indicator_o        11 excellent, 10 good, 01 bad, 00 default
module note_scroll_controller_hit_judge
   import note_scroll_controller_pkg::*;
#(
   parameter int HOLD_FRAMES = 30
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] btn_i,
   input  logic [2:0] slot_hit_i,
   input  logic [2:0] slot_pre_i,
   input  logic       shift_i,
   input  logic       vsync_pulse_i,
   input  logic       busy_i,
   output logic [1:0] indicator_o
);

   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

   logic [2:0]        btn_prev_q, btn_prev_d;
   logic              judged_q, judged_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]        ind_q, ind_d;

   logic press;
   logic take;
   logic miss;

   always_comb begin
      // A press is a new non-zero code; holding a button is not a new press.
      press = busy_i && (btn_i != ARW_NONE) && (btn_i != btn_prev_q);
      take  = press && !judged_q;
      // A press landing on the shift cycle counts for the outgoing step and
      // therefore suppresses that step's miss.
      miss  = busy_i && shift_i && (slot_hit_i != ARW_NONE) && !judged_q && !take;

      btn_prev_d = btn_i;
      judged_d   = judged_q;
      hold_cnt_d = hold_cnt_q;
      ind_d      = ind_q;

      if (!busy_i) begin
         judged_d   = 1'b0;
         hold_cnt_d = '0;
         ind_d      = IND_DEFAULT;
      end else begin
         // Shift wins over press so a shift-cycle press leaves the new step open.
         if (shift_i) begin
            judged_d = 1'b0;
         end else if (press) begin
            judged_d = 1'b1;
         end

         if (take) begin
            ind_d      = grade_press(btn_i, slot_hit_i, slot_pre_i);
            hold_cnt_d = HOLD_W'(HOLD_FRAMES);
         end else if (miss) begin
            ind_d      = IND_BAD;
            hold_cnt_d = HOLD_W'(HOLD_FRAMES);
         end else if (vsync_pulse_i && hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            if (hold_cnt_q == HOLD_W'(1)) begin
               ind_d = IND_DEFAULT;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         btn_prev_q <= ARW_NONE;
         judged_q   <= 1'b0;
         hold_cnt_q <= '0;
         ind_q      <= IND_DEFAULT;
      end else begin
         btn_prev_q <= btn_prev_d;
         judged_q   <= judged_d;
         hold_cnt_q <= hold_cnt_d;
         ind_q      <= ind_d;
      end
   end

   assign indicator_o = ind_q;

endmodule

// File: rtl/note_scroll_controller.sv
// Note-lane sequencer: fetches one chart entry per beat from a synchronous
// ROM, scrolls the shared arrow array one slot per beat (always inside
// vertical blanking) and judges both players against the hit zone.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   start              1-cycle pulse, starts a song when idle
//   vsync_pulse        1-cycle pulse at start of vertical blanking
//   chart_addr         chart ROM address
//   chart_data         chart ROM data, one cycle after chart_addr
//   p1_btn, p2_btn     player pad codes
//   arrow_array        slot k at [3k+2:3k]; slot 0 newest, slot N_STATES-1 hit zone
//   p1_indicator,
//   p2_indicator       judgement display codes
//   busy               song in progress
//   done               1-cycle pulse once the lane has fully drained
//   dbg_state          sequencer FSM state
//
// Handshake: start and vsync_pulse are single-cycle strobes sampled on the
// rising clock edge; there is no back-pressure. A strobe arriving while the
// FSM cannot act on it (start while busy, vsync outside RUN) is dropped.
module note_scroll_controller
   import note_scroll_controller_pkg::*;
#(
   parameter int N_STATES    = 26,
   parameter int BEAT_FRAMES = 8,
   parameter int CHART_AW    = 8,
   parameter int HOLD_FRAMES = 30
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  vsync_pulse,
   output logic [CHART_AW-1:0]   chart_addr,
   input  logic [2:0]            chart_data,
   input  logic [2:0]            p1_btn,
   input  logic [2:0]            p2_btn,
   output logic [3*N_STATES-1:0] arrow_array,
   output logic [1:0]            p1_indicator,
   output logic [1:0]            p2_indicator,
   output logic                  busy,
   output logic                  done,
   output scroll_state_e         dbg_state
);

   scroll_state_e               state_q;
   logic [7:0]                  frame_cnt_q;
   logic [CHART_AW-1:0]         chart_addr_q;
   logic [2:0]                  next_arrow_q;
   logic                        end_seen_q;
   logic [N_STATES-1:0][2:0]    slots_q;
   logic                        busy_q;
   logic                        done_q;

   logic                        shift;
   logic [2:0]                  fill;

   assign shift = (state_q == ST_SHIFT);
   // Once the end marker has been latched, only blanks enter the lane.
   assign fill  = end_seen_q ? ARW_NONE : next_arrow_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         frame_cnt_q  <= '0;
         chart_addr_q <= '0;
         next_arrow_q <= ARW_NONE;
         end_seen_q   <= 1'b0;
         slots_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  slots_q      <= '0;
                  chart_addr_q <= '0;
                  frame_cnt_q  <= '0;
                  next_arrow_q <= ARW_NONE;
                  end_seen_q   <= 1'b0;
                  busy_q       <= 1'b1;
                  state_q      <= ST_FETCH;
               end
            end
            // Address held for one cycle so the ROM output is valid in LATCH.
            ST_FETCH: state_q <= ST_LATCH;
            ST_LATCH: begin
               if (chart_data == ARW_END) begin
                  end_seen_q   <= 1'b1;
                  next_arrow_q <= ARW_NONE;
               end else begin
                  next_arrow_q <= chart_data;
               end
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (vsync_pulse) begin
                  if (frame_cnt_q == 8'(BEAT_FRAMES - 1)) begin
                     frame_cnt_q <= '0;
                     state_q     <= ST_SHIFT;
                  end else begin
                     frame_cnt_q <= frame_cnt_q + 8'd1;
                  end
               end
            end
            ST_SHIFT: begin
               slots_q <= {slots_q[N_STATES-2:0], fill};
               if (end_seen_q) begin
                  state_q <= ST_DRAIN;
               end else if (chart_addr_q == {CHART_AW{1'b1}}) begin
                  // Last ROM word consumed: finish without wrapping the address.
                  end_seen_q <= 1'b1;
                  state_q    <= ST_DRAIN;
               end else begin
                  chart_addr_q <= chart_addr_q + 1'b1;
                  state_q      <= ST_FETCH;
               end
            end
            ST_DRAIN: begin
               if (slots_q == '0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   note_scroll_controller_hit_judge #(
      .HOLD_FRAMES(HOLD_FRAMES)
   ) u_p1_judge (
      .clock        (clock),
      .reset        (reset),
      .btn_i        (p1_btn),
      .slot_hit_i   (slots_q[N_STATES-1]),
      .slot_pre_i   (slots_q[N_STATES-2]),
      .shift_i      (shift),
      .vsync_pulse_i(vsync_pulse),
      .busy_i       (busy_q),
      .indicator_o  (p1_indicator)
   );

   note_scroll_controller_hit_judge #(
      .HOLD_FRAMES(HOLD_FRAMES)
   ) u_p2_judge (
      .clock        (clock),
      .reset        (reset),
      .btn_i        (p2_btn),
      .slot_hit_i   (slots_q[N_STATES-1]),
      .slot_pre_i   (slots_q[N_STATES-2]),
      .shift_i      (shift),
      .vsync_pulse_i(vsync_pulse),
      .busy_i       (busy_q),
      .indicator_o  (p2_indicator)
   );

   assign chart_addr  = chart_addr_q;
   assign arrow_array = slots_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign dbg_state   = state_q;

endmodule
